axi_master_arbiter: RTL

//  Shares the single AXI4 io_master port of the core between two requesters:

---
 rtl/axi_master_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_arbiter.sv
// ---------------------------------------------------------------------------
// axi_master_arbiter
//
// Shares one AXI4 master port between two requesters:
//   port 0 (s0_*) : instruction fetch, read only (AR, R)
//   port 1 (s1_*) : load/store unit, read and write (AR, R, AW, W, B)
//   m_*           : full AXI4 master towards the io_master pins
//
// Only one downstream transaction is in flight at a time. Arbitration is
// round robin between the two ports, and it is decided in IDLE only.
//
// Ports:
//   clock, reset    single clock, asynchronous active-high reset
//   s0_ar*, s0_r*   fetch read-address / read-data channels
//   s1_ar*, s1_r*   LSU read-address / read-data channels
//   s1_aw*, s1_w*   LSU write-address / write-data channels
//   s1_b*           LSU write-response channel
//   m_*             downstream master channels
//   state_dbg       current FSM state (IDLE=0 RD_ADDR=1 RD_DATA=2
//                   WR_ADDR=3 WR_RESP=4)
//   grant_dbg       currently granted port
//
// Handshake semantics (all channels): a beat transfers on a rising clock edge
// where valid and ready are both high. The arbiter never makes any s_*ready
// depend on the same port's s_*valid; readies come from the registered
// state/grant and the downstream m_*ready only.
// ---------------------------------------------------------------------------
module axi_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    // port 0: fetch read channels
    input  logic                s0_arvalid,
    output logic                s0_arready,
    input  logic [ADDR_W-1:0]   s0_araddr,
    input  logic [ID_W-1:0]     s0_arid,
    input  logic [7:0]          s0_arlen,
    input  logic [2:0]          s0_arsize,
    input  logic [1:0]          s0_arburst,
    output logic                s0_rvalid,
    input  logic                s0_rready,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic [1:0]          s0_rresp,
    output logic                s0_rlast,
    output logic [ID_W-1:0]     s0_rid,
    // port 1: LSU read channels
    input  logic                s1_arvalid,
    output logic                s1_arready,
    input  logic [ADDR_W-1:0]   s1_araddr,
    input  logic [ID_W-1:0]     s1_arid,
    input  logic [7:0]          s1_arlen,
    input  logic [2:0]          s1_arsize,
    input  logic [1:0]          s1_arburst,
    output logic                s1_rvalid,
    input  logic                s1_rready,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic [1:0]          s1_rresp,
    output logic                s1_rlast,
    output logic [ID_W-1:0]     s1_rid,
    // port 1: LSU write channels
    input  logic                s1_awvalid,
    output logic                s1_awready,
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic [ID_W-1:0]     s1_awid,
    input  logic [7:0]          s1_awlen,
    input  logic [2:0]          s1_awsize,
    input  logic [1:0]          s1_awburst,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic                s1_wlast,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    output logic [1:0]          s1_bresp,
    output logic [ID_W-1:0]     s1_bid,
    // downstream master
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [ID_W-1:0]     m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic [ID_W-1:0]     m_rid,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [ID_W-1:0]     m_awid,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    input  logic [ID_W-1:0]     m_bid,
    // debug
    output logic [2:0]          state_dbg,
    output logic                grant_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t state;
    logic   grant;       // 0 = fetch, 1 = LSU
    logic   last_grant;
    logic   aw_done;
    logic   w_done;

    logic   req0;
    logic   req1;
    logic   pick;
    logic   aw_done_n;
    logic   w_done_n;

    assign state_dbg = state;
    assign grant_dbg = grant;

    // Request decode and round-robin choice; with both requesting, the port
    // that did not win last time gets the bus.
    always_comb begin
        req0 = s0_arvalid;
        req1 = s1_arvalid | s1_awvalid;
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
    end

    // Completion flags for the two independent write channels. A flag also
    // counts as done in the cycle its handshake happens so AW and W may
    // finish together.
    always_comb begin
        aw_done_n = aw_done | (m_awvalid & m_awready);
        w_done_n  = w_done  | (m_wvalid & m_wready & s1_wlast);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant      <= pick;
                        last_grant <= pick;
                        // A pending LSU write wins over a pending LSU read.
                        if (pick && s1_awvalid) begin
                            state <= WR_ADDR;
                        end else begin
                            state <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_arvalid && m_arready) begin
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid && m_rready && m_rlast) begin
                        state <= IDLE;
                    end
                end
                WR_ADDR: begin
                    if (aw_done_n && w_done_n) begin
                        state   <= WR_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done_n;
                        w_done  <= w_done_n;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid && m_bready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel routing. Every output is qualified by the state (and grant), so
    // an asynchronous reset drops all valid/ready outputs immediately.
    always_comb begin
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        s0_rdata   = '0;
        s0_rresp   = '0;
        s0_rlast   = 1'b0;
        s0_rid     = '0;
        s1_rdata   = '0;
        s1_rresp   = '0;
        s1_rlast   = 1'b0;
        s1_rid     = '0;
        s1_awready = 1'b0;
        s1_wready  = 1'b0;
        s1_bvalid  = 1'b0;
        s1_bresp   = '0;
        s1_bid     = '0;
        m_arvalid  = 1'b0;
        m_araddr   = '0;
        m_arid     = '0;
        m_arlen    = '0;
        m_arsize   = '0;
        m_arburst  = '0;
        m_rready   = 1'b0;
        m_awvalid  = 1'b0;
        m_awaddr   = '0;
        m_awid     = '0;
        m_awlen    = '0;
        m_awsize   = '0;
        m_awburst  = '0;
        m_wvalid   = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wlast    = 1'b0;
        m_bready   = 1'b0;

        case (state)
            RD_ADDR: begin
                if (grant) begin
                    m_arvalid  = s1_arvalid;
                    m_araddr   = s1_araddr;
                    m_arid     = s1_arid;
                    m_arlen    = s1_arlen;
                    m_arsize   = s1_arsize;
                    m_arburst  = s1_arburst;
                    s1_arready = m_arready;
                end else begin
                    m_arvalid  = s0_arvalid;
                    m_araddr   = s0_araddr;
                    m_arid     = s0_arid;
                    m_arlen    = s0_arlen;
                    m_arsize   = s0_arsize;
                    m_arburst  = s0_arburst;
                    s0_arready = m_arready;
                end
            end
            RD_DATA: begin
                if (grant) begin
                    s1_rvalid = m_rvalid;
                    s1_rdata  = m_rdata;
                    s1_rresp  = m_rresp;
                    s1_rlast  = m_rlast;
                    s1_rid    = m_rid;
                    m_rready  = s1_rready;
                end else begin
                    s0_rvalid = m_rvalid;
                    s0_rdata  = m_rdata;
                    s0_rresp  = m_rresp;
                    s0_rlast  = m_rlast;
                    s0_rid    = m_rid;
                    m_rready  = s0_rready;
                end
            end
            WR_ADDR: begin
                if (grant) begin
                    m_awaddr   = s1_awaddr;
                    m_awid     = s1_awid;
                    m_awlen    = s1_awlen;
                    m_awsize   = s1_awsize;
                    m_awburst  = s1_awburst;
                    m_wdata    = s1_wdata;
                    m_wstrb    = s1_wstrb;
                    m_wlast    = s1_wlast;
                    // A channel that already finished is closed off.
                    m_awvalid  = s1_awvalid & ~aw_done;
                    s1_awready = m_awready  & ~aw_done;
                    m_wvalid   = s1_wvalid  & ~w_done;
                    s1_wready  = m_wready   & ~w_done;
                end
            end
            WR_RESP: begin
                if (grant) begin
                    s1_bvalid = m_bvalid;
                    s1_bresp  = m_bresp;
                    s1_bid    = m_bid;
                    m_bready  = s1_bready;
                end
            end
            default: ;
        endcase
    end

endmodule
